// File: rtl/cla_nibble_seq_adder_if.sv
// Operand/result handshake bundle for cla_nibble_seq_adder.
// Carries the sub select when CLA_SEQ_SUBTRACT_EN is defined.
interface cla_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SEQ_SUBTRACT_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef CLA_SEQ_SUBTRACT_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Sequential WIDTH-bit adder: one shared 4-bit carry-lookahead stage, one nibble per clock.
// Optional subtract mode when CLA_SEQ_SUBTRACT_EN is defined.
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input logic                   clk,
    input logic                   rst,
    cla_nibble_seq_adder_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [4:0]       nib_res;

    // Returns {carry_out, sum[3:0]} with every carry in two-level lookahead form.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        nib_res = cla4(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
`ifdef CLA_SEQ_SUBTRACT_EN
                    // A - B computed as A + ~B + 1; cin has no meaning in this mode.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = nib_res[3:0];
                carry_d             = nib_res[4];
                if (idx_q == IW'(NIB - 1)) begin
                    cout_d  = nib_res[4];
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Multi-cycle WIDTH-bit adder that processes one 4-bit slice per clock through a single 4-bit carry-lookahead nibble stage.
- Registers the carry between slices and runs a valid/ready handshake on both the operand side and the result side.
- Shares one CLA nibble across all nibble positions, trading area for latency. Sits between a register-file/operand source and a result sink in the arithmetic datapath.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of 4 and >= 8.
- NIB (localparam), WIDTH/4: number of nibble steps per operation.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand source has a, b, cin valid.
- in_ready  output  1  block can accept operands (IDLE state only).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum and cout valid (DONE state only).
- out_ready  input  1  sink accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry register=0, sum=0, cout=0, out_valid=0, busy=0. in_ready=1 from the following cycle. Reset aborts any RUN or DONE operation; the partial result is discarded.
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin into operand registers, carry<=cin, idx<=0, sum<=0, and go to RUN.
  - RUN: in_ready=0. Each cycle, feed nibble idx of A/B and the carry register through the CLA nibble. Write the 4-bit result into sum[4*idx+3:4*idx], carry<=nibble carry-out, idx<=idx+1. When idx==NIB-1, also set cout<=nibble carry-out and go to DONE.
  - DONE: out_valid=1; sum and cout are held stable. On out_ready go to IDLE. in_valid is ignored (no accept in the same cycle).
- CLA nibble logic:
  - p=a^b, g=a&b per bit.
  - Full lookahead: c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3 and c4 expanded the same way.
  - s_i=p_i^c_i.
  - Must be arithmetically exact for all 2^9 nibble input combinations.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one result per NIB+2 cycles when out_ready is tied high.
- Width rules:
  - Sum wraps modulo 2^WIDTH; overflow is visible only through cout.
  - idx is clog2(NIB) bits and never wraps past NIB-1.
- Boundary cases:
  - in_valid held high during RUN/DONE: ignored; operands stay latched.
  - out_ready held low: DONE persists indefinitely with outputs stable.
  - out_ready high on the DONE entry cycle: one cycle of out_valid, then IDLE.
  - rst and in_valid high together: reset wins.

Optional Feature:
- Macro: CLA_SEQ_SUBTRACT_EN.
- When defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1: B is bit-inverted at latch, the carry register is forced to 1 (cin ignored), and the result is A-B mod 2^WIDTH.
  - cout=1 means no borrow (A>=B unsigned).
  - sub=0: behaviour identical to the base block.
- When undefined: no sub port; add only.

Test Plan:
- Basic add: WIDTH=16, a=0x1234, b=0x4321, cin=0 -> out_valid 4 cycles after accept; sum=0x5555, cout=0, busy high through DONE.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 nibbles). Also a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0.
- Backpressure: out_ready low 5 cycles in DONE with in_valid pulsed high -> sum/cout stable, in_ready=0, no new operands accepted. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst after 2 RUN cycles of 0xABCD+0x1111 -> next cycle all outputs 0 and state IDLE. Then 0x0001+0x0002 -> sum=0x0003, cout=0.
- Back-to-back with out_ready=1 and in_valid=1 throughout: 0x8000+0x8000 then 0x7FFF+0x0001 -> results 0x0000/cout=1, then 0x8000/cout=0; accepts spaced exactly 6 cycles apart.
- With CLA_SEQ_SUBTRACT_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
